// File: rtl/param_cache.sv
`default_nettype none
// ============================================================================
// Module   : param_cache
// Desc     : Direct-mapped, write-back, write-allocate cache with a byte-wide
//            memory port. Optional hit/miss counters enabled by CACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module param_cache #(
    parameter int ADDR_W         = 16,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LAT        = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pstrobe,
    input  logic              prw,
    input  logic [ADDR_W-1:0] paddress,
    input  logic [31:0]       pdata_in,
    output logic [31:0]       pdata_out,
    output logic              pready,
    output logic              sysstrobe,
    output logic              sysrw,
    output logic [ADDR_W-1:0] sysaddress,
    output logic [7:0]        sysdata_out,
    input  logic [7:0]        sysdata_in,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int c_line_bytes = 4 * WORDS_PER_LINE;
    localparam int c_off_w      = $clog2(c_line_bytes);
    localparam int c_idx_w      = $clog2(LINES);
    localparam int c_tag_w      = ADDR_W - c_off_w - c_idx_w;
    localparam int c_lat_w      = $clog2(MEM_LAT + 1);

    localparam logic [c_off_w-1:0] c_last_byte = c_off_w'(c_line_bytes - 1);
    localparam logic [c_off_w-1:0] c_word_mask = ~c_off_w'(3);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_compare   = 3'd1;
    localparam logic [2:0] c_st_respond   = 3'd2;
    localparam logic [2:0] c_st_writeback = 3'd3;
    localparam logic [2:0] c_st_fill      = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [c_off_w-1:0] r_byte;
    logic [c_lat_w-1:0] r_lat;
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [c_tag_w-1:0] r_tag  [LINES];
    logic [7:0]         r_data [LINES][c_line_bytes];

    logic [c_idx_w-1:0] w_idx;
    logic [c_tag_w-1:0] w_tag;
    logic [c_off_w-1:0] w_base;
    logic [31:0]        w_rword;
    logic               w_hit;
    logic               w_sample;
    logic               w_last_byte;

    assign w_idx       = r_addr[c_off_w +: c_idx_w];
    assign w_tag       = r_addr[ADDR_W-1 -: c_tag_w];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_sample    = (r_lat == c_lat_w'(MEM_LAT));
    assign w_last_byte = (r_byte == c_last_byte);

    // Little-endian word assembled from the four bytes of the addressed word
    always_comb begin
        w_base  = r_addr[c_off_w-1:0] & c_word_mask;
        w_rword = '0;
        for (int k = 0; k < 4; k++) begin
            w_rword[8*k +: 8] = r_data[w_idx][w_base | c_off_w'(k)];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:      if (pstrobe) w_next = c_st_compare;
            c_st_compare: begin
                if (w_hit)                                w_next = c_st_respond;
                else if (r_valid[w_idx] && r_dirty[w_idx]) w_next = c_st_writeback;
                else                                      w_next = c_st_fill;
            end
            c_st_writeback: if (w_last_byte) w_next = c_st_fill;
            c_st_fill:      if (w_sample && w_last_byte) w_next = c_st_compare;
            c_st_respond:   w_next = c_st_idle;
            default:        w_next = c_st_idle;
        endcase
    end

    always_comb begin
        pready      = (r_state == c_st_respond);
        sysstrobe   = (r_state == c_st_writeback) ||
                      ((r_state == c_st_fill) && (r_lat == '0));
        sysrw       = (r_state != c_st_writeback);
        sysaddress  = (r_state == c_st_writeback) ? {r_tag[w_idx], w_idx, r_byte}
                                                  : {w_tag, w_idx, r_byte};
        sysdata_out = r_data[w_idx][r_byte];
        pdata_out   = r_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_valid <= '0;
            r_dirty <= '0;
            r_rdata <= '0;
            r_byte  <= '0;
            r_lat   <= '0;
            r_rw    <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_st_idle: begin
                    if (pstrobe) begin
                        r_rw    <= prw;
                        r_addr  <= paddress;
                        r_wdata <= pdata_in;
                    end
                end
                c_st_compare: begin
                    r_byte <= '0;
                    r_lat  <= '0;
                    if (w_hit) begin
                        if (r_rw) r_rdata <= w_rword;
                        else      r_dirty[w_idx] <= 1'b1;
                    end
                end
                c_st_writeback: r_byte <= r_byte + c_off_w'(1);
                c_st_fill: begin
                    if (w_sample) begin
                        r_lat  <= '0;
                        r_byte <= r_byte + c_off_w'(1);
                        if (w_last_byte) begin
                            r_valid[w_idx] <= 1'b1;
                            r_dirty[w_idx] <= 1'b0;
                        end
                    end else begin
                        r_lat <= r_lat + c_lat_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; validity is governed by r_valid alone
    always_ff @(posedge clk) begin
        if (!reset) begin
            if ((r_state == c_st_fill) && w_sample) begin
                r_data[w_idx][r_byte] <= sysdata_in;
                if (w_last_byte) r_tag[w_idx] <= w_tag;
            end
            if ((r_state == c_st_compare) && w_hit && !r_rw) begin
                for (int k = 0; k < 4; k++) begin
                    r_data[w_idx][w_base | c_off_w'(k)] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic        r_first;
    logic [15:0] r_hits;
    logic [15:0] r_misses;

    // Only the first COMPARE of a request is counted; the post-fill revisit is not
    always_ff @(posedge clk) begin
        if (reset) begin
            r_first  <= 1'b0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            if ((r_state == c_st_idle) && pstrobe) r_first <= 1'b1;
            if (r_state == c_st_compare) begin
                r_first <= 1'b0;
                if (r_first) begin
                    if (w_hit) begin
                        if (r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
                    end else begin
                        if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
                    end
                end
            end
        end
    end

    assign hit_count  = r_hits;
    assign miss_count = r_misses;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_cache
// Desc     : Directed vector bench for param_cache (16 lines, 4 words, MEM_LAT=1)
//            with a byte memory whose byte at A powers up as A[7:0].
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_cache;

`ifdef CACHE_STATS_EN
    localparam bit c_stats = 1'b1;
`else
    localparam bit c_stats = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pstrobe = 1'b0;
    logic        prw = 1'b1;
    logic [15:0] paddress = '0;
    logic [31:0] pdata_in = '0;
    logic [31:0] pdata_out;
    logic        pready;
    logic        sysstrobe;
    logic        sysrw;
    logic [15:0] sysaddress;
    logic [7:0]  sysdata_out;
    logic [7:0]  sysdata_in = '0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    param_cache #(
        .ADDR_W(16), .LINES(16), .WORDS_PER_LINE(4), .MEM_LAT(1)
    ) dut (
        .clk(clk), .reset(reset),
        .pstrobe(pstrobe), .prw(prw), .paddress(paddress),
        .pdata_in(pdata_in), .pdata_out(pdata_out), .pready(pready),
        .sysstrobe(sysstrobe), .sysrw(sysrw), .sysaddress(sysaddress),
        .sysdata_out(sysdata_out), .sysdata_in(sysdata_in),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } strobe_t;

    strobe_t    slog[$];
    logic [7:0] wmem [int];

    // Byte memory: written bytes override the A[7:0] power-up pattern
    always @(negedge clk) begin
        if (sysstrobe) begin
            slog.push_back('{sysrw, sysaddress, sysdata_out, cyc});
            if (!sysrw) wmem[int'(sysaddress)] = sysdata_out;
            else sysdata_in = wmem.exists(int'(sysaddress)) ? wmem[int'(sysaddress)]
                                                            : sysaddress[7:0];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic rw, input logic [15:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rdata,
                           output logic [15:0] hits, output logic [15:0] misses);
        @(negedge clk);
        pstrobe = 1'b1; prw = rw; paddress = a; pdata_in = d;
        @(posedge clk);
        #1 pstrobe = 1'b0;
        lat = -1; rdata = 'x; hits = 'x; misses = 'x;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (pready) begin
                lat = n; rdata = pdata_out; hits = hit_count; misses = miss_count;
                break;
            end
        end
    endtask

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_nstb;
        int          exp_hits;
        int          exp_miss;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [15:0] h, m;
        int          bad;
        int          rel;
        int          npr;
        logic [31:0] dbe;
        logic [15:0] a;
        logic [7:0]  eb;

        vecs[0] = '{1'b1, 16'h0010, 32'h0,        32'h13121110, 35, 16, 0, 1};
        vecs[1] = '{1'b1, 16'h0014, 32'h0,        32'h17161514,  2,  0, 1, 1};
        vecs[2] = '{1'b0, 16'h0018, 32'hDEADBEEF, 32'h17161514,  2,  0, 2, 1};
        vecs[3] = '{1'b1, 16'h0018, 32'h0,        32'hDEADBEEF,  2,  0, 3, 1};
        vecs[4] = '{1'b1, 16'h0118, 32'h0,        32'h1B1A1918, 51, 32, 3, 2};
        vecs[5] = '{1'b0, 16'h0224, 32'h11223344, 32'h1B1A1918, 35, 16, 3, 3};
        vecs[6] = '{1'b1, 16'h0224, 32'h0,        32'h11223344,  2,  0, 4, 3};
        vecs[7] = '{1'b1, 16'h0010, 32'h0,        32'h13121110, 35, 16, 4, 4};
        vecs[8] = '{1'b1, 16'h0018, 32'h0,        32'hDEADBEEF,  2,  0, 5, 4};
        dbe = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_pready", {31'b0, pready}, 32'd0);
        chk("rst_sysstrobe", {31'b0, sysstrobe}, 32'd0);
        chk("rst_sysrw", {31'b0, sysrw}, 32'd1);
        chk("rst_pdata_out", pdata_out, 32'h0);
        chk("rst_hit_count", {16'b0, hit_count}, 32'd0);
        chk("rst_miss_count", {16'b0, miss_count}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            slog.delete();
            run_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, lat, rd, h, m);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_pdata_out", i), rd, vecs[i].exp_data);
            chk($sformatf("v%0d_strobes", i), slog.size(), vecs[i].exp_nstb);
            chk($sformatf("v%0d_hit_count", i), {16'b0, h}, c_stats ? vecs[i].exp_hits : 0);
            chk($sformatf("v%0d_miss_count", i), {16'b0, m}, c_stats ? vecs[i].exp_miss : 0);
            @(negedge clk);
            chk($sformatf("v%0d_pready_pulse", i), {31'b0, pready}, 32'd0);

            if (vecs[i].addr == 16'h0010) begin
                bad = 0;
                for (int j = 0; j < 16; j++) begin
                    if (j >= slog.size()) bad++;
                    else if (slog[j].rw !== 1'b1 || slog[j].addr !== 16'(16'h0010 + j) ||
                             (j > 0 && slog[j].cyc - slog[j-1].cyc != 2)) bad++;
                end
                chk($sformatf("v%0d_fill_sequence", i), bad, 0);
            end
            if (vecs[i].addr == 16'h0118) begin
                bad = 0;
                for (int j = 0; j < 32; j++) begin
                    if (j >= slog.size()) bad++;
                    else if (j < 16) begin
                        a  = 16'(16'h0010 + j);
                        eb = (j >= 8 && j < 12) ? dbe[8*(j-8) +: 8] : a[7:0];
                        if (slog[j].rw !== 1'b0 || slog[j].addr !== a ||
                            slog[j].data !== eb ||
                            (j > 0 && slog[j].cyc - slog[j-1].cyc != 1)) bad++;
                    end else begin
                        if (slog[j].rw !== 1'b1 || slog[j].addr !== 16'(16'h0110 + j - 16) ||
                            slog[j].cyc - slog[j-1].cyc != ((j == 16) ? 1 : 2)) bad++;
                    end
                end
                chk("dirty_evict_sequence", bad, 0);
            end
        end

        // Reset in the middle of a line fill
        @(negedge clk);
        pstrobe = 1'b1; prw = 1'b1; paddress = 16'h0330;
        @(posedge clk);
        #1 pstrobe = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rel = cyc;
        chk("abort_sysstrobe", {31'b0, sysstrobe}, 32'd0);
        chk("abort_pdata_out", pdata_out, 32'h0);
        chk("abort_hit_count", {16'b0, hit_count}, 32'd0);
        chk("abort_miss_count", {16'b0, miss_count}, 32'd0);
        npr = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (pready) npr++;
        end
        chk("abort_no_pready", npr, 0);
        bad = 0;
        foreach (slog[k]) if (slog[k].cyc >= rel) bad++;
        chk("abort_no_strobes", bad, 0);

        slog.delete();
        run_req(1'b1, 16'h0010, 32'h0, lat, rd, h, m);
        chk("post_reset_latency", lat, 35);
        chk("post_reset_strobes", slog.size(), 16);
        chk("post_reset_pdata_out", rd, 32'h13121110);
        chk("post_reset_miss_count", {16'b0, m}, c_stats ? 32'd1 : 32'd0);
        chk("post_reset_hit_count", {16'b0, h}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
